nrs_ls_averager: RTL and testbench
==================================

# nrs_ls_averager

Channel-estimation stage directly downstream of the signed complex multiplier. The multiplier stores per-pilot least-squares channel estimates (17-bit signed real/imag) in its small register file. This block reads those NUM_EST entries through the multiplier's read port, sums them, and divides by NUM_EST with round-half-up. It presents one averaged estimate per pilot group to the interpolation stage.

## Interface
Parameters:
- WIDTH_R_I, 16, input sample width; estimate width is WIDTH_R_I+1.
- NUM_EST, 4, number of stored estimates averaged; power of two, at least 2.
- ADDR_W, 2, read-address width; equals log2(NUM_EST).

Ports:
- clk  input  1  single clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to average the currently stored estimates.
- h_r_in  input  WIDTH_R_I+1  signed real estimate; the upstream register-file entry at rd_addr, combinational, same cycle.
- h_i_in  input  WIDTH_R_I+1  signed imaginary estimate; same timing as h_r_in.
- rd_addr  output  ADDR_W  read address to the upstream register file.
- busy  output  1  high whenever state is not IDLE.
- h_avg_r  output  WIDTH_R_I+1  signed averaged real estimate, registered.
- h_avg_i  output  WIDTH_R_I+1  signed averaged imaginary estimate, registered.
- avg_valid  output  1  one-cycle pulse when h_avg_r and h_avg_i update.

## Operation
- FSM states:
  - IDLE: on start=1, clear the accumulators, set rd_addr=0, go to READ.
  - READ: each cycle, add the sign-extended h_r_in and h_i_in to acc_r and acc_i, then increment rd_addr. After the read at rd_addr=NUM_EST-1, go to DONE.
  - DONE: register the rounded averages, pulse avg_valid, return to IDLE, set rd_addr=0.
- Accumulator width is WIDTH_R_I+1+ADDR_W bits, signed (19 bits at defaults), so it cannot overflow.
- Rounding: avg = (acc + 2^(ADDR_W-1)) >>> ADDR_W, an arithmetic shift (round half toward +inf). The result always fits in WIDTH_R_I+1 bits, so no saturation is needed.
- start while busy (READ or DONE) is ignored and not queued.
- h_avg_r and h_avg_i hold their value between DONE cycles.
- Reset, including mid-operation: state=IDLE, rd_addr=0, accumulators=0, h_avg_r=h_avg_i=0, avg_valid=0, busy=0. An aborted run never produces avg_valid.

## Timing
- start sampled high at edge n:
  - busy=1 and rd_addr=0 during cycle n+1.
  - rd_addr=k during cycle n+1+k, for k=0..NUM_EST-1.
  - DONE during cycle n+1+NUM_EST.
  - avg_valid=1 and outputs updated in cycle n+2+NUM_EST (n+6 at defaults), registered.
- busy falls together with the avg_valid pulse.
- Earliest accepted next start is the avg_valid cycle. Minimum period between runs is NUM_EST+2 cycles.
- Upstream must not write entries while busy=1; this block does not check for it.

## Structure
- Shared channel-estimation package holds the EST_W=WIDTH_R_I+1 constant, the FSM state encoding (IDLE, READ, DONE), and the rounding-offset constant.
- One natural sub-module, est_round_shift: a parameterized signed add-offset and arithmetic right shift, instantiated twice (real and imaginary).

## Test plan
- Constant data: all four entries (1000, -500) -> avg_valid at start+6, output (1000, -500), rd_addr sequence 0,1,2,3.
- Round-half-up:
  - real entries 1,1,1,0 -> 1.
  - real entries -1,-1,-1,0 -> -1.
  - real entries -2,0,0,0 -> 0.
  - imaginary entries 2,0,0,0 -> 1.
- Extremes: all entries 65535 -> 65535; all entries -65536 -> -65536; alternating 65535 and -65536 -> 0 (sum -2, +2, >>>2).
- start pulsed during READ and again in the DONE cycle -> exactly one avg_valid; the next start accepted in the avg_valid cycle gives a second avg_valid 6 cycles later.
- rst asserted asynchronously while rd_addr=2 -> outputs immediately 0, no avg_valid; a fresh start afterwards averages correctly from rd_addr=0.
- Random sweep of 1000 runs with random entries, checked against a reference model using sum plus 2, arithmetic shift right by 2 -> zero mismatches.

Source files
------------

// File: rtl/nrs_ls_averager_pkg.sv
// Shared channel-estimation constants: estimate width, averager FSM encoding
// and the round-half-up offset used before the divide-by-shift.
package nrs_ls_averager_pkg;

  localparam int DEF_WIDTH_R_I = 16;
  localparam int DEF_NUM_EST   = 4;
  localparam int DEF_ADDR_W    = 2;
  localparam int EST_W         = DEF_WIDTH_R_I + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int round_ofs(input int shift);
    return 1 << (shift - 1);
  endfunction

  localparam int ROUND_OFS = round_ofs(DEF_ADDR_W);

endpackage

// File: rtl/nrs_ls_averager_if.sv
// Averager port bundle: start request, upstream register-file read port and
// the averaged estimate handed to the interpolation stage.
interface nrs_ls_averager_if
  import nrs_ls_averager_pkg::*;
#(
  parameter int EW = EST_W,
  parameter int AW = DEF_ADDR_W
) ();

  logic                 start;
  logic signed [EW-1:0] h_r_in;
  logic signed [EW-1:0] h_i_in;
  logic        [AW-1:0] rd_addr;
  logic                 busy;
  logic signed [EW-1:0] h_avg_r;
  logic signed [EW-1:0] h_avg_i;
  logic                 avg_valid;

  modport master (
    output start, h_r_in, h_i_in,
    input  rd_addr, busy, h_avg_r, h_avg_i, avg_valid
  );

  modport slave (
    input  start, h_r_in, h_i_in,
    output rd_addr, busy, h_avg_r, h_avg_i, avg_valid
  );

endinterface

// File: rtl/nrs_ls_averager_round.sv
// Signed add-offset then arithmetic right shift: divide by 2^SHIFT with
// rounding half toward +inf.
module est_round_shift
  import nrs_ls_averager_pkg::*;
#(
  parameter int IN_W  = 19,
  parameter int SHIFT = 2
) (
  input  logic signed [IN_W-1:0]       i_acc,
  output logic signed [IN_W-SHIFT-1:0] o_avg
);

  localparam logic signed [IN_W-1:0] OFS = IN_W'(round_ofs(SHIFT));

  // Headroom: NUM_EST full-scale estimates plus the offset stay below 2^(IN_W-1).
  logic signed [IN_W-1:0] w_sum;

  assign w_sum = i_acc + OFS;
  assign o_avg = w_sum[IN_W-1:SHIFT];

endmodule

// File: rtl/nrs_ls_averager.sv
// Reads NUM_EST stored LS channel estimates from the multiplier's register
// file, sums them and presents the rounded mean as one registered result.
module nrs_ls_averager
  import nrs_ls_averager_pkg::*;
#(
  parameter int WIDTH_R_I = DEF_WIDTH_R_I,
  parameter int NUM_EST   = DEF_NUM_EST,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  nrs_ls_averager_if.slave bus
);

  localparam int AVG_W = WIDTH_R_I + 1;
  localparam int ACC_W = AVG_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_EST - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic        [ADDR_W-1:0] r_rd_addr;
  logic signed [ACC_W-1:0]  r_acc_r;
  logic signed [ACC_W-1:0]  r_acc_i;
  logic signed [AVG_W-1:0]  r_avg_r;
  logic signed [AVG_W-1:0]  r_avg_i;
  logic                     r_avg_valid;
  logic signed [AVG_W-1:0]  w_rnd_r;
  logic signed [AVG_W-1:0]  w_rnd_i;
  logic                     w_busy;
  logic                     w_acc_clr;
  logic                     w_acc_en;
  logic                     w_done;
  logic                     w_last;

  assign w_last = (r_rd_addr == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_READ;
      ST_READ: if (w_last)    w_next = ST_DONE;
      ST_DONE:                w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  // start outside IDLE is dropped, never queued.
  always_comb begin
    w_busy    = (r_state != ST_IDLE);
    w_acc_clr = (r_state == ST_IDLE) && bus.start;
    w_acc_en  = (r_state == ST_READ);
    w_done    = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr   <= '0;
      r_acc_r     <= '0;
      r_acc_i     <= '0;
      r_avg_r     <= '0;
      r_avg_i     <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= w_done;
      if (w_acc_clr) begin
        r_acc_r   <= '0;
        r_acc_i   <= '0;
        r_rd_addr <= '0;
      end else if (w_acc_en) begin
        r_acc_r   <= r_acc_r + {{ADDR_W{bus.h_r_in[AVG_W-1]}}, bus.h_r_in};
        r_acc_i   <= r_acc_i + {{ADDR_W{bus.h_i_in[AVG_W-1]}}, bus.h_i_in};
        r_rd_addr <= w_last ? '0 : r_rd_addr + 1'b1;
      end
      if (w_done) begin
        r_avg_r   <= w_rnd_r;
        r_avg_i   <= w_rnd_i;
        r_rd_addr <= '0;
      end
    end
  end

  est_round_shift #(.IN_W(ACC_W), .SHIFT(ADDR_W)) u_round_r (
    .i_acc (r_acc_r),
    .o_avg (w_rnd_r)
  );

  est_round_shift #(.IN_W(ACC_W), .SHIFT(ADDR_W)) u_round_i (
    .i_acc (r_acc_i),
    .o_avg (w_rnd_i)
  );

  assign bus.rd_addr   = r_rd_addr;
  assign bus.busy      = w_busy;
  assign bus.h_avg_r   = r_avg_r;
  assign bus.h_avg_i   = r_avg_i;
  assign bus.avg_valid = r_avg_valid;

endmodule

// File: tb/tb_nrs_ls_averager.sv
// Bench for nrs_ls_averager: upstream register file modelled as two arrays,
// expected averages from plain integer arithmetic.
module tb_nrs_ls_averager;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nrs_ls_averager_if #(.EW(17), .AW(2)) bus ();

  nrs_ls_averager dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic signed [16:0] mem_r [4];
  logic signed [16:0] mem_i [4];

  assign bus.h_r_in = mem_r[bus.rd_addr];
  assign bus.h_i_in = mem_i[bus.rd_addr];

  int n_checks = 0;
  int n_fail   = 0;

  int                 obs_lat;
  logic signed [16:0] obs_r;
  logic signed [16:0] obs_i;
  logic               obs_busy;
  logic [1:0]         obs_addr [4];

  function automatic int ref_avg(input int a0, input int a1, input int a2, input int a3);
    int s;
    s = a0 + a1 + a2 + a3 + 2;
    return s >>> 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int r0, input int r1, input int r2, input int r3,
                      input int i0, input int i1, input int i2, input int i3);
    mem_r[0] = 17'(r0); mem_r[1] = 17'(r1); mem_r[2] = 17'(r2); mem_r[3] = 17'(r3);
    mem_i[0] = 17'(i0); mem_i[1] = 17'(i1); mem_i[2] = 17'(i2); mem_i[3] = 17'(i3);
  endtask

  // Pulses start, then watches cycles n+1.. for avg_valid (bounded).
  task automatic do_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    obs_lat = -1;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 4) obs_addr[c-1] = bus.rd_addr;
      if (bus.avg_valid) begin
        obs_lat  = c;
        obs_r    = bus.h_avg_r;
        obs_i    = bus.h_avg_i;
        obs_busy = bus.busy;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.avg_valid !== 1'b0 || bus.rd_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got busy=%b valid=%b addr=%0d want 0 0 0", bus.busy, bus.avg_valid, bus.rd_addr);
    end
    n_checks++;
    if (bus.h_avg_r !== 17'sd0 || bus.h_avg_i !== 17'sd0) begin
      n_fail++;
      $display("FAIL reset_avg got (%0d,%0d) want (0,0)", bus.h_avg_r, bus.h_avg_i);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_constant();
    load(1000, 1000, 1000, 1000, -500, -500, -500, -500);
    do_run();
    n_checks++;
    if (obs_lat !== 6) begin
      n_fail++;
      $display("FAIL const_latency got %0d want 6", obs_lat);
    end
    n_checks++;
    if (obs_r !== 17'sd1000 || obs_i !== -17'sd500) begin
      n_fail++;
      $display("FAIL const_value got (%0d,%0d) want (1000,-500)", obs_r, obs_i);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs_addr[k] !== 2'(k)) begin
        n_fail++;
        $display("FAIL const_rd_addr[%0d] got %0d want %0d", k, obs_addr[k], k);
      end
    end
    n_checks++;
    if (obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL const_busy_fall got %b want 0", obs_busy);
    end
  endtask

  task automatic test_rounding();
    int tr [4][4];
    int ti [4][4];
    int er [4];
    int ei [4];
    tr = '{'{1, 1, 1, 0}, '{-1, -1, -1, 0}, '{-2, 0, 0, 0}, '{0, 0, 0, 0}};
    ti = '{'{0, 0, 0, 0}, '{0, 0, 0, 0},    '{0, 0, 0, 0},  '{2, 0, 0, 0}};
    er = '{1, -1, 0, 0};
    ei = '{0, 0, 0, 1};
    for (int t = 0; t < 4; t++) begin
      load(tr[t][0], tr[t][1], tr[t][2], tr[t][3], ti[t][0], ti[t][1], ti[t][2], ti[t][3]);
      do_run();
      n_checks++;
      if (obs_lat !== 6 || obs_r !== 17'(er[t]) || obs_i !== 17'(ei[t])) begin
        n_fail++;
        $display("FAIL round_case%0d got (%0d,%0d) lat %0d want (%0d,%0d) lat 6",
                 t, obs_r, obs_i, obs_lat, er[t], ei[t]);
      end
    end
  endtask

  task automatic test_extremes();
    load(65535, 65535, 65535, 65535, -65536, -65536, -65536, -65536);
    do_run();
    n_checks++;
    if (obs_r !== 17'sd65535 || obs_i !== -17'sd65536) begin
      n_fail++;
      $display("FAIL extreme_full got (%0d,%0d) want (65535,-65536)", obs_r, obs_i);
    end
    load(65535, -65536, 65535, -65536, -65536, 65535, -65536, 65535);
    do_run();
    n_checks++;
    if (obs_r !== 17'sd0 || obs_i !== 17'sd0) begin
      n_fail++;
      $display("FAIL extreme_alt got (%0d,%0d) want (0,0)", obs_r, obs_i);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    int first_c;
    int second_c;
    logic v;
    cnt = 0; first_c = -1; second_c = -1;
    load(10, 20, 30, 40, -4, -4, -4, -5);
    bus.start = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      v = bus.avg_valid;
      if (v) begin
        cnt++;
        if (cnt == 1) first_c = c;
        else second_c = c;
      end
      bus.start = (c == 2 || c == 5 || (v && cnt == 1)) ? 1'b1 : 1'b0;
      tick();
    end
    bus.start = 1'b0;
    n_checks++;
    if (cnt !== 2) begin
      n_fail++;
      $display("FAIL b2b_valid_count got %0d want 2", cnt);
    end
    n_checks++;
    if (first_c !== 6 || second_c !== 12) begin
      n_fail++;
      $display("FAIL b2b_valid_cycles got %0d,%0d want 6,12", first_c, second_c);
    end
    n_checks++;
    if (bus.h_avg_r !== 17'(ref_avg(10, 20, 30, 40)) || bus.h_avg_i !== 17'(ref_avg(-4, -4, -4, -5))) begin
      n_fail++;
      $display("FAIL b2b_value got (%0d,%0d) want (%0d,%0d)", bus.h_avg_r, bus.h_avg_i,
               ref_avg(10, 20, 30, 40), ref_avg(-4, -4, -4, -5));
    end
  endtask

  task automatic test_async_reset();
    int vcnt;
    load(300, 300, 300, 300, -700, -700, -700, -700);
    do_run();
    load(5000, 5000, 5000, 5000, 6000, 6000, 6000, 6000);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.rd_addr !== 2'd2 || bus.h_avg_r !== 17'sd300) begin
      n_fail++;
      $display("FAIL arst_setup got addr=%0d avg_r=%0d want addr=2 avg_r=300", bus.rd_addr, bus.h_avg_r);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.h_avg_r !== 17'sd0 || bus.h_avg_i !== 17'sd0 || bus.busy !== 1'b0 || bus.rd_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL arst_immediate got avg=(%0d,%0d) busy=%b addr=%0d want 0", bus.h_avg_r, bus.h_avg_i,
               bus.busy, bus.rd_addr);
    end
    tick();
    rst = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.avg_valid) vcnt++;
      tick();
    end
    n_checks++;
    if (vcnt !== 0) begin
      n_fail++;
      $display("FAIL arst_no_valid got %0d pulses want 0", vcnt);
    end
    load(-8, 9, -10, 11, 100, 101, 102, 103);
    do_run();
    n_checks++;
    if (obs_lat !== 6 || obs_addr[0] !== 2'd0 || obs_r !== 17'(ref_avg(-8, 9, -10, 11))
        || obs_i !== 17'(ref_avg(100, 101, 102, 103))) begin
      n_fail++;
      $display("FAIL arst_fresh_run got (%0d,%0d) lat %0d addr0 %0d want (%0d,%0d) lat 6 addr0 0",
               obs_r, obs_i, obs_lat, obs_addr[0], ref_avg(-8, 9, -10, 11), ref_avg(100, 101, 102, 103));
    end
  endtask

  task automatic test_random();
    int vr [4];
    int vi [4];
    int er;
    int ei;
    for (int run = 0; run < 1000; run++) begin
      for (int k = 0; k < 4; k++) begin
        vr[k] = int'($urandom_range(131071, 0)) - 65536;
        vi[k] = int'($urandom_range(131071, 0)) - 65536;
      end
      if (run % 7 == 0) vr[0] = (run % 2 == 0) ? 65535 : -65536;
      load(vr[0], vr[1], vr[2], vr[3], vi[0], vi[1], vi[2], vi[3]);
      er = ref_avg(vr[0], vr[1], vr[2], vr[3]);
      ei = ref_avg(vi[0], vi[1], vi[2], vi[3]);
      do_run();
      n_checks++;
      if (obs_lat !== 6 || obs_r !== 17'(er) || obs_i !== 17'(ei)) begin
        n_fail++;
        $display("FAIL random_run%0d got (%0d,%0d) lat %0d want (%0d,%0d) lat 6",
                 run, obs_r, obs_i, obs_lat, er, ei);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_constant();
    test_rounding();
    test_extremes();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
